// File: rtl/adc_event_framer_if.sv
// Byte handshakes around the framer: FWFT FIFO read port and UART transmit port.
// The master side is the framer; the slave side is the FIFO/UART environment.
interface adc_event_framer_if;
   logic [7:0] fifo_data;
   logic       fifo_ready;
   logic       fifo_rd;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      input  fifo_data, fifo_ready, tx_ready,
      output fifo_rd, tx_data, tx_valid
   );

   modport slave (
      output fifo_data, fifo_ready, tx_ready,
      input  fifo_rd, tx_data, tx_valid
   );
endinterface

// File: rtl/adc_event_framer.sv
// Packs FIFO ADC bytes into SYNC/SEQ/NEV/LEN/payload frames for the UART.
// Define FRAMER_CHECKSUM_EN to append a two's-complement checksum byte.
module adc_event_framer #(
   parameter int unsigned PAYLOAD_BYTES = 1024,
   parameter logic [7:0]  SYNC0         = 8'hA5,
   parameter logic [7:0]  SYNC1         = 8'h5A
) (
   input  logic                clk,
   input  logic                Reset_n,
   adc_event_framer_if.master  bus,
   input  logic [7:0]          num_events,
   input  logic                abort,
   output logic                frame_active,
   output logic [15:0]         frame_count
);

   localparam logic [15:0] LEN = 16'(PAYLOAD_BYTES);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SYNC0,
      S_SYNC1,
      S_SEQ,
      S_NEV,
      S_LENH,
      S_LENL,
      S_PAYLOAD,
`ifdef FRAMER_CHECKSUM_EN
      S_CKSUM,
`endif
      S_DONE
   } state_t;

   state_t      state_q;
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic [7:0]  nev_q;
   logic [15:0] cnt_q;
   logic        frame_active_q;
   logic [15:0] frame_count_q;
`ifdef FRAMER_CHECKSUM_EN
   logic [7:0]  sum_q;
   logic [7:0]  sum_d;
`endif

   logic in_pay;
   logic xfer;

   // Payload bytes bypass the output register so the FIFO head streams through.
   assign in_pay       = (state_q == S_PAYLOAD);
   assign bus.tx_valid = in_pay ? bus.fifo_ready : tx_valid_q;
   assign bus.tx_data  = in_pay ? bus.fifo_data : tx_data_q;
   assign bus.fifo_rd  = in_pay & bus.fifo_ready & bus.tx_ready & ~abort;
   assign xfer         = bus.tx_valid & bus.tx_ready;
   assign frame_active = frame_active_q;
   assign frame_count  = frame_count_q;

`ifdef FRAMER_CHECKSUM_EN
   assign sum_d = sum_q + bus.tx_data;
`endif

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q        <= S_IDLE;
         tx_data_q      <= 8'h00;
         tx_valid_q     <= 1'b0;
         nev_q          <= 8'h00;
         cnt_q          <= 16'h0000;
         frame_active_q <= 1'b0;
         frame_count_q  <= 16'h0000;
`ifdef FRAMER_CHECKSUM_EN
         sum_q          <= 8'h00;
`endif
      end else if (abort && state_q != S_IDLE) begin
         state_q        <= S_IDLE;
         tx_valid_q     <= 1'b0;
         frame_active_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (bus.fifo_ready) begin
               nev_q          <= num_events;
               tx_data_q      <= SYNC0;
               tx_valid_q     <= 1'b1;
               frame_active_q <= 1'b1;
               state_q        <= S_SYNC0;
            end
            S_SYNC0: begin
`ifdef FRAMER_CHECKSUM_EN
               sum_q <= 8'h00;
`endif
               if (xfer) begin
                  tx_data_q <= SYNC1;
                  state_q   <= S_SYNC1;
               end
            end
            S_SYNC1: if (xfer) begin
               tx_data_q <= frame_count_q[7:0];
               state_q   <= S_SEQ;
            end
            S_SEQ: if (xfer) begin
`ifdef FRAMER_CHECKSUM_EN
               sum_q <= sum_d;
`endif
               tx_data_q <= nev_q;
               state_q   <= S_NEV;
            end
            S_NEV: if (xfer) begin
`ifdef FRAMER_CHECKSUM_EN
               sum_q <= sum_d;
`endif
               tx_data_q <= LEN[15:8];
               state_q   <= S_LENH;
            end
            S_LENH: if (xfer) begin
`ifdef FRAMER_CHECKSUM_EN
               sum_q <= sum_d;
`endif
               tx_data_q <= LEN[7:0];
               state_q   <= S_LENL;
            end
            S_LENL: if (xfer) begin
`ifdef FRAMER_CHECKSUM_EN
               sum_q <= sum_d;
`endif
               tx_data_q  <= 8'h00;
               tx_valid_q <= 1'b0;
               cnt_q      <= LEN;
               state_q    <= S_PAYLOAD;
            end
            S_PAYLOAD: if (xfer) begin
               cnt_q <= cnt_q - 16'd1;
`ifdef FRAMER_CHECKSUM_EN
               sum_q <= sum_d;
               if (cnt_q == 16'd1) begin
                  tx_data_q  <= 8'h00 - sum_d;
                  tx_valid_q <= 1'b1;
                  state_q    <= S_CKSUM;
               end
`else
               if (cnt_q == 16'd1) begin
                  frame_active_q <= 1'b0;
                  state_q        <= S_DONE;
               end
`endif
            end
`ifdef FRAMER_CHECKSUM_EN
            S_CKSUM: if (xfer) begin
               tx_data_q      <= 8'h00;
               tx_valid_q     <= 1'b0;
               frame_active_q <= 1'b0;
               state_q        <= S_DONE;
            end
`endif
            S_DONE: begin
               frame_count_q <= frame_count_q + 16'd1;
               state_q       <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_event_framer.sv
// Scoreboard bench for adc_event_framer with PAYLOAD_BYTES=4.
// Expected frame layout follows FRAMER_CHECKSUM_EN as compiled.
module tb_adc_event_framer;
   localparam int PB = 4;
   localparam logic [15:0] LEN = 16'(PB);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  nev;
   logic        abort;
   logic        fa;
   logic [15:0] fc;

   adc_event_framer_if bus();

   adc_event_framer #(.PAYLOAD_BYTES(PB)) dut (
      .clk          (clk),
      .Reset_n      (rst_n),
      .bus          (bus),
      .num_events   (nev),
      .abort        (abort),
      .frame_active (fa),
      .frame_count  (fc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [7:0] fq[$];
   logic [7:0] eq[$];
   bit   fifo_en = 1'b1;
   bit   rdy_rand = 1'b0;
   bit   hold = 1'b0;
   bit   pop_pend = 1'b0;
   bit   stall = 1'b0;
   logic [7:0] stall_d = 8'h00;
   int   got = 0;
   int   pops = 0;
   logic [7:0] seq = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] n, input logic [7:0] b);
      logic [7:0] s;
      logic [7:0] p;
      eq.push_back(8'hA5);
      eq.push_back(8'h5A);
      eq.push_back(seq);
      eq.push_back(n);
      eq.push_back(LEN[15:8]);
      eq.push_back(LEN[7:0]);
      s = seq + n + LEN[15:8] + LEN[7:0];
      for (int i = 0; i < PB; i++) begin
         p = b + 8'(i);
         eq.push_back(p);
         s = s + p;
      end
`ifdef FRAMER_CHECKSUM_EN
      eq.push_back(8'h00 - s);
`endif
      seq = seq + 8'd1;
   endtask

   task automatic fill(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) fq.push_back(b + 8'(i));
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (eq.size() > 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (eq.size() > 0) check({tag, "_timeout"}, 32'(eq.size()), 32'd0);
      repeat (3) @(negedge clk);
      #3;
   endtask

   task automatic wait_got(input string tag, input int n);
      int k = 0;
      do begin
         @(negedge clk);
         #3;
         k++;
      end while (got < n && k < 1000);
      if (got < n) check({tag, "_got_timeout"}, 32'(got), 32'(n));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #3;
      fq.delete();
      eq.delete();
      seq = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.fifo_data  = 8'h00;
      bus.fifo_ready = 1'b0;
      bus.tx_ready   = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (pop_pend && fq.size() > 0) void'(fq.pop_front());
         pop_pend = 1'b0;
         if (hold) bus.tx_ready = 1'b0;
         else if (rdy_rand) bus.tx_ready = 1'($urandom_range(0, 1));
         else bus.tx_ready = 1'b1;
         bus.fifo_ready = fifo_en && fq.size() > 0;
         bus.fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
         #1;
         if (rst_n && !abort) begin
            if (stall) begin
               check("stable_valid", 32'(bus.tx_valid), 32'd1);
               check("stable_data", 32'(bus.tx_data), 32'(stall_d));
            end
            if (bus.fifo_rd) begin
               check("rd_qual", 32'({bus.fifo_ready, bus.tx_ready}), 32'd3);
               pop_pend = 1'b1;
               pops++;
            end
            if (bus.tx_valid && bus.tx_ready) begin
               if (eq.size() == 0)
                  check("extra_byte", 32'(bus.tx_data), 32'h100);
               else
                  check("byte", 32'(bus.tx_data), 32'(eq.pop_front()));
               got++;
            end
            stall   = bus.tx_valid && !bus.tx_ready;
            stall_d = bus.tx_data;
         end else begin
            stall = 1'b0;
         end
      end
   end

   initial begin
      nev   = 8'd2;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      check("rst_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_data", 32'(bus.tx_data), 32'd0);
      check("rst_rd", 32'(bus.fifo_rd), 32'd0);
      check("rst_active", 32'(fa), 32'd0);
      check("rst_count", 32'(fc), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // T1: straight frame; num_events changes after it is latched
      pops = 0;
      push_frame(8'd2, 8'd1);
      fill(8'd1, PB);
      repeat (3) @(negedge clk);
      nev = 8'd9;
      wait_done("t1", 200);
      check("t1_count", 32'(fc), 32'd1);
      check("t1_pops", 32'(pops), 32'(PB));
      check("t1_active", 32'(fa), 32'd0);
      nev = 8'd2;

      // T2: random back-pressure
      do_reset();
      pops = 0;
      rdy_rand = 1'b1;
      push_frame(8'd2, 8'd1);
      fill(8'd1, PB);
      wait_done("t2", 400);
      rdy_rand = 1'b0;
      check("t2_count", 32'(fc), 32'd1);
      check("t2_pops", 32'(pops), 32'(PB));

      // T3: FIFO runs dry mid-payload
      do_reset();
      got = 0;
      push_frame(8'd2, 8'd1);
      fill(8'd1, 2);
      wait_got("t3", 8);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #3;
         check("t3_gap_valid", 32'(bus.tx_valid), 32'd0);
         check("t3_gap_rd", 32'(bus.fifo_rd), 32'd0);
      end
      check("t3_gap_active", 32'(fa), 32'd1);
      fill(8'd3, 2);
      wait_done("t3", 200);
      check("t3_count", 32'(fc), 32'd1);

      // T4: abort after two payload bytes
      do_reset();
      got = 0;
      push_frame(8'd2, 8'd1);
      fill(8'd1, PB);
      wait_got("t4", 8);
      @(negedge clk);
      abort = 1'b1;
      hold  = 1'b1;
      #3;
      eq.delete();
      seq = 8'h00;
      push_frame(8'd2, 8'd3);
      fill(8'd5, 2);
      @(negedge clk);
      abort = 1'b0;
      hold  = 1'b0;
      #3;
      check("t4_valid", 32'(bus.tx_valid), 32'd0);
      check("t4_rd", 32'(bus.fifo_rd), 32'd0);
      check("t4_count", 32'(fc), 32'd0);
      check("t4_active", 32'(fa), 32'd0);
      wait_done("t4", 200);
      check("t4_count2", 32'(fc), 32'd1);

      // T6: 256 back-to-back frames, then reset mid-frame
      do_reset();
      pops = 0;
      for (int f = 0; f < 256; f++) begin
         push_frame(8'd2, 8'(f));
         fill(8'(f), PB);
      end
      wait_done("t6", 8000);
      check("t6_count", 32'(fc), 32'd256);
      check("t6_pops", 32'(pops), 32'(256 * PB));
      got = 0;
      push_frame(8'd2, 8'd7);
      fill(8'd7, PB);
      wait_got("t6r", 7);
      @(negedge clk);
      rst_n = 1'b0;
      #3;
      check("t6r_valid", 32'(bus.tx_valid), 32'd0);
      check("t6r_data", 32'(bus.tx_data), 32'd0);
      check("t6r_rd", 32'(bus.fifo_rd), 32'd0);
      check("t6r_active", 32'(fa), 32'd0);
      check("t6r_count", 32'(fc), 32'd0);
      fq.delete();
      eq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
